// File: rtl/hand_ctrl_pkg.sv
// hand_ctrl_pkg: gesture and FSM enums shared by the gesture controller,
// plus the saturating move helper and the raw-code decoder.
package hand_ctrl_pkg;

  typedef enum logic [2:0] {
    NONE, UP, DOWN, LEFT, RIGHT, NEXT, PREV, CENTER
  } gesture_e;

  typedef enum logic [1:0] {
    IDLE, MOVE, HOLD
  } state_e;

  localparam int CW = 16;

  // Moves val by step towards 0 (dec) or towards max, clamping at the
  // end of the range; the sum carries one extra bit so it cannot wrap.
  function automatic logic [CW-1:0] clamp_move(
    input logic [CW-1:0] val,
    input logic [CW-1:0] step,
    input logic [CW-1:0] max,
    input logic          dec
  );
    logic [CW:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    if (dec)
      return (val >= step) ? val - step : '0;
    return (sum > {1'b0, max}) ? max : sum[CW-1:0];
  endfunction

  // Codes 8..15 carry no meaning and collapse onto NONE.
  function automatic gesture_e to_gesture(input logic [3:0] code);
    return code[3] ? NONE : gesture_e'(code[2:0]);
  endfunction

endpackage

// File: rtl/hand_gesture_controller_debouncer.sv
// gesture_debouncer: accepts a code once DEBOUNCE identical samples are seen.
// In: clk_in, rst_n_in, new_data_in, data_in[3:0], timeout_in. Out: accept_out, code_out.
module gesture_debouncer
  import hand_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       new_data_in,
  input  logic [3:0] data_in,
  input  logic       timeout_in,
  output logic       accept_out,
  output gesture_e   code_out
);

  localparam int CNW = $clog2(DEBOUNCE + 1);
  localparam logic [CNW-1:0] DB = CNW'(DEBOUNCE);

  gesture_e       sample;
  gesture_e       cand;
  logic [CNW-1:0] cnt;
  logic [CNW-1:0] cnt_nxt;

  assign sample = to_gesture(data_in);

  always_comb begin
    cnt_nxt = CNW'(1);
    if (sample == cand)
      cnt_nxt = (cnt >= DB) ? DB : cnt + 1'b1;
  end

  // A timeout with no sample stands in for an accepted NONE.
  assign accept_out = new_data_in ? (cnt_nxt >= DB) : timeout_in;
  assign code_out   = new_data_in ? sample : NONE;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cand <= NONE;
      cnt  <= '0;
    end else if (new_data_in) begin
      cand <= sample;
      cnt  <= cnt_nxt;
    end else if (timeout_in) begin
      cand <= NONE;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/hand_gesture_controller.sv
// hand_gesture_controller: gesture codes -> clamped window offsets and filter mode.
// In: clk_in, rst_n_in, new_data_in, data_in. Out: h_offset, v_offset, filter_mode, update_out.
module hand_gesture_controller
  import hand_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH    = 240,
  parameter int FRAME_HEIGHT   = 320,
  parameter int WIN_WIDTH      = 131,
  parameter int WIN_HEIGHT     = 131,
  parameter int NUM_MODES      = 5,
  parameter int STEP_MIN       = 1,
  parameter int STEP_MAX       = 8,
  parameter int RAMP_COUNT     = 4,
  parameter int DEBOUNCE       = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            new_data_in,
  input  logic [3:0]                      data_in,
  output logic [$clog2(FRAME_WIDTH)-1:0]  h_offset,
  output logic [$clog2(FRAME_HEIGHT)-1:0] v_offset,
  output logic [$clog2(NUM_MODES)-1:0]    filter_mode,
  output logic                            update_out
);

  localparam int HW    = $clog2(FRAME_WIDTH);
  localparam int VW    = $clog2(FRAME_HEIGHT);
  localparam int MW    = $clog2(NUM_MODES);
  localparam int SW    = $clog2(STEP_MAX + 1);
  localparam int RW    = $clog2(RAMP_COUNT + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int H_MAX = FRAME_WIDTH - WIN_WIDTH;
  localparam int V_MAX = FRAME_HEIGHT - WIN_HEIGHT;

  localparam logic [HW-1:0] H_CTR  = HW'(H_MAX / 2);
  localparam logic [VW-1:0] V_CTR  = VW'(V_MAX / 2);
  localparam logic [SW-1:0] S_MIN  = SW'(STEP_MIN);
  localparam logic [SW-1:0] S_MAX  = SW'(STEP_MAX);
  localparam logic [RW-1:0] R_LAST = RW'(RAMP_COUNT - 1);
  localparam logic [MW-1:0] M_LAST = MW'(NUM_MODES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          timeout;
  logic          acc;
  gesture_e      code;

  state_e        state, state_n;
  gesture_e      dir, dir_n;
  gesture_e      last, last_n;
  logic [SW-1:0] step, step_n;
  logic [RW-1:0] rep, rep_n;
  logic [HW-1:0] h_n;
  logic [VW-1:0] v_n;
  logic [MW-1:0] mode_n;
  logic [SW-1:0] mv;
  logic          same_dir;

  // A sample in the same cycle as the tick suppresses it.
  assign timeout = !new_data_in && (idle_cnt == T_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      idle_cnt <= '0;
    else if (new_data_in || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  gesture_debouncer #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .new_data_in(new_data_in),
    .data_in    (data_in),
    .timeout_in (timeout),
    .accept_out (acc),
    .code_out   (code)
  );

  assign same_dir = (state == MOVE) && (code == dir);
  assign mv       = same_dir ? step : S_MIN;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    last_n  = last;
    step_n  = step;
    rep_n   = rep;
    h_n     = h_offset;
    v_n     = v_offset;
    mode_n  = filter_mode;
    if (acc) begin
      unique case (1'b1)
        (code == NONE): state_n = IDLE;
        (code inside {UP, DOWN, LEFT, RIGHT}): begin
          state_n = MOVE;
          dir_n   = code;
          step_n  = S_MIN;
          rep_n   = '0;
          if (same_dir) begin
            step_n = step;
            rep_n  = rep + 1'b1;
            // The move uses the old step; doubling applies afterwards.
            if (rep == R_LAST) begin
              rep_n  = '0;
              step_n = (step >= S_MAX) ? S_MAX : SW'(step << 1);
            end
          end
          unique case (code)
            UP:      v_n = VW'(clamp_move(CW'(v_offset), CW'(mv),
                                          CW'(V_MAX), 1'b1));
            DOWN:    v_n = VW'(clamp_move(CW'(v_offset), CW'(mv),
                                          CW'(V_MAX), 1'b0));
            LEFT:    h_n = HW'(clamp_move(CW'(h_offset), CW'(mv),
                                          CW'(H_MAX), 1'b1));
            default: h_n = HW'(clamp_move(CW'(h_offset), CW'(mv),
                                          CW'(H_MAX), 1'b0));
          endcase
        end
        default: begin
          state_n = HOLD;
          last_n  = code;
          // A held mode/recenter code acts only on its first acceptance.
          if (!(state == HOLD && code == last)) begin
            unique case (code)
              NEXT: mode_n = (filter_mode == M_LAST) ?
                             '0 : filter_mode + 1'b1;
              PREV: mode_n = (filter_mode == '0) ?
                             M_LAST : filter_mode - 1'b1;
              default: begin
                h_n    = H_CTR;
                v_n    = V_CTR;
                step_n = S_MIN;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      dir         <= NONE;
      last        <= NONE;
      step        <= S_MIN;
      rep         <= '0;
      h_offset    <= H_CTR;
      v_offset    <= V_CTR;
      filter_mode <= '0;
      update_out  <= 1'b0;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      last        <= last_n;
      step        <= step_n;
      rep         <= rep_n;
      h_offset    <= h_n;
      v_offset    <= v_n;
      filter_mode <= mode_n;
      update_out  <= (h_n != h_offset) || (v_n != v_offset) ||
                     (mode_n != filter_mode);
    end
  end

endmodule

// File: tb/tb_hand_gesture_controller.sv
// tb_hand_gesture_controller: scoreboard bench for hand_gesture_controller.
// A behavioural model queues expected outputs; a monitor checks each update pulse.
module tb_hand_gesture_controller;

  localparam int TO     = 300;
  localparam int H_MAX  = 240 - 131;
  localparam int V_MAX  = 320 - 131;
  localparam int NMODES = 5;
  localparam int SMIN   = 1;
  localparam int SMAX   = 8;
  localparam int RAMP   = 4;
  localparam int DEB    = 2;

  logic       clk_in      = 1'b0;
  logic       rst_n_in    = 1'b0;
  logic       new_data_in = 1'b0;
  logic [3:0] data_in     = 4'd0;
  logic [7:0] h_offset;
  logic [8:0] v_offset;
  logic [2:0] filter_mode;
  logic       update_out;

  hand_gesture_controller #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .new_data_in(new_data_in),
    .data_in    (data_in),
    .h_offset   (h_offset),
    .v_offset   (v_offset),
    .filter_mode(filter_mode),
    .update_out (update_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int h;
    int v;
    int m;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model state: position, mode, last code seen and its run length,
  // idle cycles, direction being moved (0: none), code held (0: none).
  int m_h, m_v, m_mode;
  int m_last, m_run, m_idle;
  int m_dir, m_held, m_step, m_hits;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_h = H_MAX / 2;
    m_v = V_MAX / 2;
    m_mode = 0;
    m_last = 0;
    m_run = 0;
    m_idle = 0;
    m_dir = 0;
    m_held = 0;
    m_step = SMIN;
    m_hits = 0;
  endfunction

  function automatic void m_move(input int c, input int s);
    case (c)
      1: m_v = (m_v - s < 0) ? 0 : m_v - s;
      2: m_v = (m_v + s > V_MAX) ? V_MAX : m_v + s;
      3: m_h = (m_h - s < 0) ? 0 : m_h - s;
      default: m_h = (m_h + s > H_MAX) ? H_MAX : m_h + s;
    endcase
  endfunction

  function automatic void m_apply(input int c);
    if (c == 0) begin
      m_dir = 0;
      m_held = 0;
    end else if (c <= 4) begin
      m_held = 0;
      if (m_dir == c) begin
        m_move(c, m_step);
        m_hits++;
        if (m_hits == RAMP) begin
          m_hits = 0;
          m_step = (2 * m_step > SMAX) ? SMAX : 2 * m_step;
        end
      end else begin
        m_dir = c;
        m_step = SMIN;
        m_hits = 0;
        m_move(c, SMIN);
      end
    end else begin
      m_dir = 0;
      if (m_held != c) begin
        m_held = c;
        if (c == 5) m_mode = (m_mode + 1) % NMODES;
        else if (c == 6) m_mode = (m_mode + NMODES - 1) % NMODES;
        else begin
          m_h = H_MAX / 2;
          m_v = V_MAX / 2;
          m_step = SMIN;
        end
      end
    end
  endfunction

  // One clock cycle of the model, for the inputs seen at the next edge.
  function automatic void m_cycle(input bit nd, input int d);
    int c;
    int ph, pv, pm;
    ph = m_h;
    pv = m_v;
    pm = m_mode;
    if (nd) begin
      m_idle = 0;
      c = (d > 7) ? 0 : d;
      if (c == m_last) m_run++;
      else begin
        m_last = c;
        m_run = 1;
      end
      if (m_run >= DEB) m_apply(c);
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_idle = 0;
        m_last = 0;
        m_run = 0;
        m_apply(0);
      end
    end
    if (ph != m_h || pv != m_v || pm != m_mode)
      exp_q.push_back('{m_h, m_v, m_mode});
  endfunction

  task automatic drive(input bit nd, input int d);
    @(negedge clk_in);
    new_data_in = nd;
    data_in = 4'(d);
    m_cycle(nd, d);
  endtask

  task automatic burst(input int d, input int n);
    repeat (n) drive(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2;
    chk("pre_reset_drain", exp_q.size(), 0);
    exp_q.delete();
    rst_n_in = 1'b0;
    new_data_in = 1'b0;
    #1;
    chk("rst_h", int'(h_offset), H_MAX / 2);
    chk("rst_v", int'(v_offset), V_MAX / 2);
    chk("rst_mode", int'(filter_mode), 0);
    chk("rst_update", int'(update_out), 0);
    m_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_cycle(1'b0, 0);
  endtask

  // Monitor: every update pulse must match the oldest queued expectation.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && update_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_update h %0d v %0d mode %0d expected no pulse",
                   h_offset, v_offset, filter_mode);
        end else begin
          e = exp_q.pop_front();
          chk("upd_h", int'(h_offset), e.h);
          chk("upd_v", int'(v_offset), e.v);
          chk("upd_mode", int'(filter_mode), e.m);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk_in);
    do_reset();

    drive(1'b1, 4);
    drive(1'b0, 0);
    chk("single_sample_h", int'(h_offset), 54);
    drive(1'b1, 4);
    idle(2);
    chk("pair_h", int'(h_offset), 55);

    burst(1, 15);
    burst(3, 2);
    idle(2);
    chk("ramp_v", int'(v_offset), m_v);
    chk("restart_h", int'(h_offset), 54);

    burst(2, 40);
    idle(2);
    chk("clamp_down_v", int'(v_offset), V_MAX);
    burst(3, 60);
    idle(2);
    chk("clamp_left_h", int'(h_offset), 0);

    burst(5, 10);
    idle(2);
    chk("next_once", int'(filter_mode), 1);
    burst(0, 2);
    burst(6, 2);
    idle(2);
    chk("prev_mode", int'(filter_mode), 0);
    burst(0, 2);
    burst(6, 2);
    idle(2);
    chk("prev_wrap", int'(filter_mode), NMODES - 1);

    burst(1, 60);
    idle(2);
    chk("clamp_up_v", int'(v_offset), 0);
    burst(7, 2);
    idle(2);
    chk("center_h", int'(h_offset), 54);
    chk("center_v", int'(v_offset), 94);

    drive(1'b1, 4);
    idle(TO + 5);
    drive(1'b1, 4);
    idle(2);
    chk("timeout_cand_reset_h", int'(h_offset), 54);
    drive(1'b1, 4);
    idle(2);
    chk("timeout_step_h", int'(h_offset), 55);

    drive(1'b1, 1);
    idle(TO - 1);
    drive(1'b1, 1);
    idle(2);
    chk("tick_collision_v", int'(v_offset), m_v);

    burst(1, 12);
    do_reset();
    burst(2, 2);
    idle(2);
    chk("post_reset_step_v", int'(v_offset), 95);

    for (int k = 0; k < 300; k++) begin
      int r, c, n;
      r = $urandom_range(0, 19);
      c = 0;
      if (r < 11) c = $urandom_range(1, 4);
      else if (r < 15) c = $urandom_range(5, 7);
      else if (r < 18) c = $urandom_range(8, 15);
      if (r == 19) idle(TO - 1 + $urandom_range(0, 2));
      else begin
        n = $urandom_range(1, 12);
        for (int j = 0; j < n; j++)
          drive($urandom_range(0, 4) != 0, c);
      end
    end

    idle(3);
    chk("final_drain", exp_q.size(), 0);
    chk("final_h", int'(h_offset), m_h);
    chk("final_v", int'(v_offset), m_v);
    chk("final_mode", int'(filter_mode), m_mode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
